// File: rtl/vedic_pkg.sv
// Shared helpers for the pipelined Vedic multiplier: operand-width legality, derived widths, S2 recombination.
// Latency: n/a (constants and pure combinational functions only).
// Backpressure: n/a.
package vedic_pkg;

  // Widest operand the recombination helper is sized for.
  localparam int MAX_W = 64;

  // Operand width must be a power of two, at least 4, and fit the helper below.
  function automatic bit width_ok(input int w);
    return (w >= 4) && (w <= MAX_W) && ((w & (w - 1)) == 0);
  endfunction

  // Width of each operand half fed to the recursive core.
  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  // Width of the full product.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // HH<<w + (LH+HL)<<(w/2) + LL. The middle sum keeps its carry (w+1 bits) and the
  // final add cannot overflow 2*w bits; callers truncate the result to 2*w bits.
  function automatic logic [2*MAX_W-1:0] shift_add(
    input logic [MAX_W-1:0] ll,
    input logic [MAX_W-1:0] lh,
    input logic [MAX_W-1:0] hl,
    input logic [MAX_W-1:0] hh,
    input int               w
  );
    logic [2*MAX_W-1:0] mid;
    mid = {{MAX_W{1'b0}}, lh} + {{MAX_W{1'b0}}, hl};
    return ({{MAX_W{1'b0}}, hh} << w) + (mid << (w / 2)) + {{MAX_W{1'b0}}, ll};
  endfunction

endpackage

// File: rtl/vedic_nbits.sv
// Recursive combinational N-bit Vedic (Urdhva-Tiryagbhyam) multiplier; the 2-bit vedic cell is the leaf.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; no handshake, output follows inputs.
module vedic_nbits #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);

  if (N == 2) begin : g_leaf
    logic t1, t2, c1, hh;

    // 2-bit vedic cell: vertical products on the ends, crosswise sum in the middle.
    always_comb begin
      t1     = a_i[1] & b_i[0];
      t2     = a_i[0] & b_i[1];
      c1     = t1 & t2;
      hh     = a_i[1] & b_i[1];
      p_o[0] = a_i[0] & b_i[0];
      p_o[1] = t1 ^ t2;
      p_o[2] = hh ^ c1;
      p_o[3] = hh & c1;
    end
  end else begin : g_rec
    localparam int H = N / 2;

    logic [N-1:0] ll, lh, hl, hh;
    logic [N:0]   mid;

    vedic_nbits #(.N(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
    vedic_nbits #(.N(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[N-1:H]), .p_o(lh));
    vedic_nbits #(.N(H)) u_hl (.a_i(a_i[N-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
    vedic_nbits #(.N(H)) u_hh (.a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(hh));

    // Crosswise terms summed with carry, then placed at the half-width offset
    // above the concatenated vertical terms (HH:LL never overlap).
    always_comb begin
      mid = {1'b0, lh} + {1'b0, hl};
      p_o = {hh, ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
    end
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Two-stage pipelined WIDTH-bit Vedic multiplier (S1: four half-width products, S2: shifted add); VEDIC_SIGNED_EN adds signed mode.
// Latency: 2 cycles from input transfer to OUT_VALID; one product per cycle sustained.
// Backpressure: valid/ready both sides; IN_READY = !s1_valid || !OUT_VALID || OUT_READY (combinational from OUT_READY).
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef VEDIC_SIGNED_EN
  input  logic               IN_SIGNED,
`endif
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] Q
);

  localparam int HALF_W = half_w(WIDTH);
  localparam int PROD_W = prod_w(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be a power of two between 4 and 64");
  end

  // Operands as seen by the unsigned core (magnitudes in signed mode).
  logic [WIDTH-1:0] op_a, op_b;

  // Half-width products straight out of the cores.
  logic [WIDTH-1:0] ll_p, lh_p, hl_p, hh_p;

  // Stage 1 registers.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] ll_q, ll_d, lh_q, lh_d, hl_q, hl_d, hh_q, hh_d;

  // Stage 2 registers (the outputs).
  logic              out_valid_q, out_valid_d;
  logic [PROD_W-1:0] q_q, q_d;

  // Handshake and combine signals.
  logic              s1_adv, s2_adv, in_xfer;
  logic [PROD_W-1:0] q_next;

`ifdef VEDIC_SIGNED_EN
  logic sign_in, sign_q, sign_d;

  // Two's-complement magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    sign_in = IN_SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
    op_a    = (IN_SIGNED && A[WIDTH-1]) ? -A : A;
    op_b    = (IN_SIGNED && B[WIDTH-1]) ? -B : B;
  end
`else
  assign op_a = A;
  assign op_b = B;
`endif

  vedic_nbits #(.N(HALF_W)) u_ll (.a_i(op_a[HALF_W-1:0]),     .b_i(op_b[HALF_W-1:0]),     .p_o(ll_p));
  vedic_nbits #(.N(HALF_W)) u_lh (.a_i(op_a[HALF_W-1:0]),     .b_i(op_b[WIDTH-1:HALF_W]), .p_o(lh_p));
  vedic_nbits #(.N(HALF_W)) u_hl (.a_i(op_a[WIDTH-1:HALF_W]), .b_i(op_b[HALF_W-1:0]),     .p_o(hl_p));
  vedic_nbits #(.N(HALF_W)) u_hh (.a_i(op_a[WIDTH-1:HALF_W]), .b_i(op_b[WIDTH-1:HALF_W]), .p_o(hh_p));

  // Stall chain: S2 moves when its slot is empty or being drained; S1 moves with S2.
  always_comb begin
    s2_adv   = !out_valid_q || OUT_READY;
    s1_adv   = s2_adv;
    IN_READY = !s1_valid_q || s1_adv;
    in_xfer  = IN_VALID && IN_READY;
  end

  // S1 next state: capture products only on an input transfer, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    ll_d       = ll_q;
    lh_d       = lh_q;
    hl_d       = hl_q;
    hh_d       = hh_q;
`ifdef VEDIC_SIGNED_EN
    sign_d     = sign_q;
`endif
    if (IN_READY) begin
      s1_valid_d = IN_VALID;
    end
    if (in_xfer) begin
      ll_d = ll_p;
      lh_d = lh_p;
      hl_d = hl_p;
      hh_d = hh_p;
`ifdef VEDIC_SIGNED_EN
      sign_d = sign_in;
`endif
    end
  end

  // S2 next state: recombine S1 products; Q only changes when a new product moves in.
  always_comb begin
    q_next = PROD_W'(shift_add(MAX_W'(ll_q), MAX_W'(lh_q), MAX_W'(hl_q), MAX_W'(hh_q), WIDTH));
`ifdef VEDIC_SIGNED_EN
    if (sign_q) begin
      q_next = -q_next;
    end
`endif
    out_valid_d = out_valid_q;
    q_d         = q_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        q_d = q_next;
      end
    end
  end

  // Pipeline registers with synchronous reset that discards anything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      ll_q        <= '0;
      lh_q        <= '0;
      hl_q        <= '0;
      hh_q        <= '0;
`ifdef VEDIC_SIGNED_EN
      sign_q      <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      q_q         <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      ll_q        <= ll_d;
      lh_q        <= lh_d;
      hl_q        <= hl_d;
      hh_q        <= hh_d;
`ifdef VEDIC_SIGNED_EN
      sign_q      <= sign_d;
`endif
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign Q         = q_q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench for vedic_mult_pipe: driver pushes reference products, monitor pops on each output transfer.
// Latency: checks the 2-cycle first-result latency and 1/cycle streaming.
// Backpressure: random and directed OUT_READY stalls, Q hold checks, mid-stream reset.
module tb_vedic_mult_pipe;

  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic           IN_VALID;
  logic           IN_READY;
  logic [W-1:0]   A, B;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [2*W-1:0] Q;
`ifdef VEDIC_SIGNED_EN
  logic           IN_SIGNED;
`endif

  vedic_mult_pipe #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
`ifdef VEDIC_SIGNED_EN
    .IN_SIGNED(IN_SIGNED),
`endif
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .Q        (Q)
  );

  always #5 CLK = ~CLK;

  logic [2*W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer multiply, signed or unsigned, truncated to the product width.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg);
    longint pa, pb, p;
    if (sg) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    p = pa * pb;
    return p[2*W-1:0];
  endfunction

  // One cycle of stimulus, applied after the falling edge; IN_READY checked against pipe occupancy.
  task automatic drive(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit sg, input bit ordy);
    @(negedge CLK);
    IN_VALID  = iv;
    A         = a;
    B         = b;
    OUT_READY = ordy;
`ifdef VEDIC_SIGNED_EN
    IN_SIGNED = sg;
`endif
    #1;
    check("in_ready", 64'(IN_READY), 64'(ordy || (exp_q.size() < 2)));
    if (iv && IN_READY) exp_q.push_back(ref_mul(a, b, sg));
  endtask

  function automatic bit rand_sg();
`ifdef VEDIC_SIGNED_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: compare every output transfer against the scoreboard; verify hold under stall.
  initial begin : monitor
    bit             held;
    logic [2*W-1:0] hq;
    held = 1'b0;
    hq   = '0;
    forever begin
      @(negedge CLK);
      #2;
      if (RST) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 64'(OUT_VALID), 64'(1));
          check("hold_q", 64'(Q), 64'(hq));
        end
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_output: got %0h, expected no output", Q);
          end else begin
            check("product", 64'(Q), 64'(exp_q.pop_front()));
          end
        end
        held = OUT_VALID && !OUT_READY;
        hq   = Q;
      end
    end
  end

  initial begin : stim
    int waited;
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    A         = '0;
    B         = '0;
`ifdef VEDIC_SIGNED_EN
    IN_SIGNED = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("reset_out_valid", 64'(OUT_VALID), 64'(0));
    check("reset_q", 64'(Q), 64'(0));
    RST = 1'b0;

    // First-result latency: 3*5 visible exactly two rising edges after being presented.
    drive(1'b1, W'(3), W'(5), 1'b0, 1'b1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    #1 check("latency_1cyc_valid", 64'(OUT_VALID), 64'(0));
    @(negedge CLK);
    #1 check("latency_2cyc_valid", 64'(OUT_VALID), 64'(1));
    check("latency_q", 64'(Q), 64'h000F);

    // All-ones and zero operand.
    drive(1'b1, W'(8'hFF), W'(8'hFF), 1'b0, 1'b1);
    drive(1'b1, W'(0), W'(8'hAB), 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b1);

    // Back-to-back stream.
    for (int i = 0; i < 16; i++)
      drive(1'b1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), rand_sg(), 1'b1);

    // Stream with a 5-cycle downstream stall in the middle.
    for (int i = 0; i < 14; i++)
      drive(1'b1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), rand_sg(),
            !(i >= 4 && i < 9));
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset with two products in flight: nothing stale may appear afterwards.
    drive(1'b1, W'(8'h12), W'(8'h34), 1'b0, 1'b0);
    drive(1'b1, W'(8'h56), W'(8'h78), 1'b0, 1'b0);
    @(negedge CLK);
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    @(negedge CLK);
    check("midreset_out_valid", 64'(OUT_VALID), 64'(0));
    exp_q.delete();
    RST = 1'b0;
    #1 check("midreset_in_ready", 64'(IN_READY), 64'(1));
    repeat (4) drive(1'b0, '0, '0, 1'b0, 1'b1);

    // Random valid and random backpressure.
    for (int i = 0; i < 40; i++)
      drive(bit'($urandom_range(0, 1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            rand_sg(), ($urandom_range(0, 3) != 0));

`ifdef VEDIC_SIGNED_EN
    // Signed corners including the most negative operand.
    drive(1'b1, W'(8'h80), W'(8'h80), 1'b1, 1'b1);
    drive(1'b1, W'(8'hFF), W'(8'h01), 1'b1, 1'b1);
    drive(1'b1, W'(8'h7F), W'(8'h80), 1'b1, 1'b1);
    drive(1'b1, W'(8'h80), W'(8'h80), 1'b0, 1'b1);
`endif

    // Drain with a bounded wait.
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      waited++;
    end
    repeat (2) @(negedge CLK);
    check("drain_pending", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier that generalises the 2-bit combinational vedic cell to WIDTH-bit operands. It uses a two-stage registered datapath with a valid/ready handshake on both sides. Throughput is one product per cycle, with backpressure support. It is the multiply unit for the datapath blocks built on top of the vedic cell library.

Parameters:
WIDTH, 8, operand width in bits; power of two, >= 4.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
IN_VALID  input  1  operand pair A/B valid
IN_READY  output  1  block accepts A/B this cycle
A  input  WIDTH  multiplicand
B  input  WIDTH  multiplier
OUT_VALID  output  1  Q holds a valid product
OUT_READY  input  1  downstream accepts Q this cycle
Q  output  2*WIDTH  product A*B

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - RST is synchronous, active-high, and sampled on the rising edge of CLK.
- Reset values:
  - OUT_VALID=0 and Q=0.
  - All internal stage-valid bits = 0 and partial-product registers = 0.
- Handshake:
  - An input transfer occurs when IN_VALID&&IN_READY on a rising edge.
  - An output transfer occurs when OUT_VALID&&OUT_READY.
  - A/B are sampled only on an input transfer.
  - Q must hold stable while OUT_VALID=1 and OUT_READY=0.
- Stage 1 (S1):
  - Split A=AH:AL and B=BH:BL, each half WIDTH/2 bits.
  - Compute four half-width products with the vedic_nbits core: LL=AL*BL, LH=AL*BH, HL=AH*BL, HH=AH*BH.
  - Register the four products plus s1_valid.
- Stage 2 (S2):
  - Q_next = HH<<WIDTH + (LH+HL)<<(WIDTH/2) + LL.
  - The middle sum is WIDTH+1 bits wide; the final add is 2*WIDTH bits wide and never overflows.
  - Register Q_next into Q and OUT_VALID.
- Latency: exactly 2 cycles from input transfer to OUT_VALID=1 when no stall is present.
- Stall logic:
  - s2_adv = !OUT_VALID || OUT_READY.
  - s1_adv = s2_adv.
  - IN_READY = !s1_valid || s1_adv. This is a combinational path from OUT_READY, which is permitted.
- Back-to-back operation: with IN_VALID=1 and OUT_READY=1 held, one product is accepted and one delivered per cycle.
- Full pipeline: when s1_valid=1, OUT_VALID=1 and OUT_READY=0, then IN_READY=0 and no state changes.
- Simultaneous events:
  - Input transfer and output transfer in the same cycle both take effect.
  - No bubble is inserted and no product is lost or duplicated.
- Reset mid-operation:
  - All in-flight products are discarded.
  - OUT_VALID=0 on the cycle after RST is sampled high.
  - IN_READY=1 on the first cycle after RST deasserts.
- Boundary: all-ones operands give Q = 2^(2*WIDTH) - 2^(WIDTH+1) + 1. For WIDTH=8, 0xFF*0xFF = 0xFE01.

Optional Feature:
- Macro: VEDIC_SIGNED_EN.
- Defined:
  - Adds port IN_SIGNED (input, 1 bit), sampled with A/B.
  - When IN_SIGNED=1, S1 takes two's-complement magnitudes of A and B and registers sign = A[MSB]^B[MSB] alongside the products.
  - S2 negates the unsigned product when sign=1.
  - -2^(WIDTH-1) magnitudes are handled correctly.
  - Latency and handshake are unchanged.
- Not defined:
  - IN_SIGNED does not exist.
  - All operands are unsigned.
  - No sign logic is synthesised.

Decomposition:
- Package vedic_pkg holds:
  - the WIDTH legality check (power of two, >= 4);
  - the HALF_W and PROD_W localparam helpers;
  - a function for the S2 shifted-add.
- Sub-module vedic_nbits: a combinational, recursive N-bit Vedic multiplier with the 2-bit vedic cell as leaf. It is instantiated four times in S1.

Test Plan:
- Reset then single op, WIDTH=8, A=3, B=5 -> OUT_VALID=1 exactly 2 cycles after transfer, Q=16'h000F.
- A=8'hFF, B=8'hFF; A=0, B=8'hAB -> Q=16'hFE01, then Q=16'h0000.
- Stream of 16 random pairs, IN_VALID=1, OUT_READY=1 -> one result per cycle, in order, matching the reference model.
- OUT_READY=0 for 5 cycles during the stream -> IN_READY=0 once the pipe is full, Q stable, no loss or duplication after release.
- RST pulsed with 2 ops in flight -> OUT_VALID=0 next cycle, stale products never appear.
- VEDIC_SIGNED_EN, IN_SIGNED=1: -128*-128 -> 16'h4000; -1*1 -> 16'hFFFF; 127*-128 -> 16'hC080.
